bram_result_reader: RTL

BRAM_RESULT_READER -- requirements
Module: bram_result_reader

---
 rtl/bram_result_reader_pkg.sv | 19 +
 rtl/bram_result_reader_row_unpacker.sv | 69 ++++++
 rtl/bram_result_reader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bram_result_reader_pkg.sv
// Shared state encoding and default geometry for the BRAM result reader.
`default_nettype none

package bram_result_reader_pkg;

  localparam int C_AWIDTH    = 9;
  localparam int C_DWIDTH    = 64;
  localparam int C_OUT_WIDTH = 16;
  localparam int C_MEM_SIZE  = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bram_result_reader_row_unpacker.sv
// Holds one BRAM row and streams it out as four lanes under valid/ready.
`default_nettype none

module bram_result_reader_row_unpacker
  import bram_result_reader_pkg::*;
#(
  parameter int DWIDTH    = C_DWIDTH,
  parameter int OUT_WIDTH = C_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_issue,
  input  logic [DWIDTH-1:0]    i_q,
  input  logic                 i_ready,
  input  logic                 i_last_row,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_last,
  output logic                 o_buf_idle,
  output logic                 o_lane3_xfer
);

  logic [DWIDTH-1:0] r_buf;
  logic [1:0]        r_lane;
  logic              r_full;
  logic              r_pend;
  logic              r_chain;

  logic [DWIDTH-1:0] w_row;
  logic              w_bypass;
  logic              w_xfer;

  // A read chained off a lane-3 transfer is presented straight from BRAM
  // data so consecutive rows stream without a gap.
  assign w_bypass     = r_pend & r_chain;
  assign w_row        = w_bypass ? i_q : r_buf;
  assign o_valid      = r_full | w_bypass;
  assign o_data       = w_row[int'(r_lane)*OUT_WIDTH +: OUT_WIDTH];
  assign o_last       = o_valid & (r_lane == 2'd3) & i_last_row;
  assign w_xfer       = o_valid & i_ready;
  assign o_lane3_xfer = w_xfer & (r_lane == 2'd3);
  assign o_buf_idle   = ~r_full & ~r_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf   <= '0;
      r_lane  <= 2'd0;
      r_full  <= 1'b0;
      r_pend  <= 1'b0;
      r_chain <= 1'b0;
    end else begin
      r_pend  <= i_issue;
      r_chain <= o_lane3_xfer;
      if (r_pend) begin
        r_buf  <= i_q;
        r_full <= 1'b1;
        r_lane <= {1'b0, w_xfer};
      end else if (w_xfer) begin
        r_lane <= r_lane + 2'd1;
        if (r_lane == 2'd3) begin
          r_full <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_result_reader.sv
// Drains a block of BRAM1 rows as a 16-bit lane stream; owns FSM, address and read issue.
`default_nettype none

module bram_result_reader
  import bram_result_reader_pkg::*;
#(
  parameter int CNT_BIT   = 31,
  parameter int AWIDTH    = C_AWIDTH,
  parameter int MEM_SIZE  = C_MEM_SIZE,
  parameter int DWIDTH    = C_DWIDTH,
  parameter int OUT_WIDTH = C_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_run_i,
  input  logic [CNT_BIT-1:0]   run_count_i,
  input  logic [DWIDTH-1:0]    q_b1_i,
  output logic [AWIDTH-1:0]    addr_b1_o,
  output logic                 ce_b1_o,
  output logic                 we_b1_o,
  output logic [DWIDTH-1:0]    d_b1_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_last_o,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o
);

  localparam int ROW_W = $clog2(MEM_SIZE + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ROW_W-1:0] r_count;
  logic [ROW_W-1:0] r_issued;

  logic [ROW_W-1:0] w_count_clamped;
  logic             w_rows_left;
  logic             w_issue;
  logic             w_buf_idle;
  logic             w_lane3_xfer;
  logic             w_last_xfer;

  assign w_count_clamped = (run_count_i > CNT_BIT'(MEM_SIZE)) ? ROW_W'(MEM_SIZE)
                                                              : ROW_W'(run_count_i);
  assign w_rows_left = (r_issued < r_count);
  // Only one row is ever buffered or in flight, so a new read waits for
  // an empty buffer or for the final lane to leave.
  assign w_issue     = (r_state == ST_RUN) && w_rows_left && (w_buf_idle || w_lane3_xfer);
  assign w_last_xfer = m_valid_o & m_ready_i & m_last_o;

  assign addr_b1_o = AWIDTH'(r_issued);
  assign ce_b1_o   = w_issue;
  assign we_b1_o   = 1'b0;
  assign d_b1_o    = '0;

  always_comb begin
    w_state_nxt = r_state;
    idle_o      = 1'b0;
    run_o       = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        idle_o = 1'b1;
        if (start_run_i) begin
          w_state_nxt = (w_count_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        run_o = 1'b1;
        if (w_last_xfer) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_issued <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && start_run_i) begin
        r_count  <= w_count_clamped;
        r_issued <= '0;
      end else if (r_state == ST_DONE) begin
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + 1'b1;
      end
    end
  end

  bram_result_reader_row_unpacker #(
    .DWIDTH    (DWIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_row_unpacker (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_issue      (w_issue),
    .i_q          (q_b1_i),
    .i_ready      (m_ready_i),
    .i_last_row   (r_issued == r_count),
    .o_valid      (m_valid_o),
    .o_data       (m_data_o),
    .o_last       (m_last_o),
    .o_buf_idle   (w_buf_idle),
    .o_lane3_xfer (w_lane3_xfer)
  );

endmodule

`default_nettype wire
